image_stream_loader: RTL and testbench

//  UART-to-BRAM image loader that fills the three input image block RAMs consumed by the 3x3 filter path.

---
 rtl/image_loader_pkg.sv | 17 +
 rtl/uart_rx_core.sv | 123 ++++++++++++
 rtl/image_stream_loader.sv | 121 ++++++++++++
 tb/tb_image_stream_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_loader_pkg.sv
// Shared definitions for the UART image loader: RX state encodings and
// word/row/address geometry of the 3x3 window RAM interface.
package image_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int BYTES_PER_WORD = 9;
  localparam int ROW_W          = 24;
  localparam int ADDR_W         = 16;
  localparam int WORD_W         = BYTES_PER_WORD * 8;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer plus IDLE/START/DATA/STOP FSM.
// byte_valid pulses for one clock with rx_byte holding the received byte;
// stop_err pulses for one clock when the stop bit is sampled low.
module uart_rx_core
  import image_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             valid_n, err_n;
  logic             rx_meta, rx_sync;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  // FSM state, bit timing counter, shift register and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      byte_valid <= valid_n;
      stop_err   <= err_n;
    end
  end

  // Next-state logic: mid-bit sampling, LSB-first data, stop-bit check.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_sync) begin
          state_n = RX_START;
          cnt_n   = '0;
        end else begin
          state_n = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          bit_n = 3'd0;
          if (!rx_sync) begin
            state_n = RX_DATA;
          end else begin
            state_n = RX_IDLE;   // glitch shorter than half a bit
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_n   = '0;
          shift_n = {rx_sync, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = RX_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rx_sync) begin
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = RX_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign rx_byte = shift;

endmodule

// File: rtl/image_stream_loader.sv
// UART-to-BRAM image loader: packs every 9 received bytes into a 3x3 window
// word and commits address and all three rows together in one clock.
// Optional feature macro: RX_TIMEOUT_EN (abort a partial word after
// TIMEOUT_CYC idle cycles and flag frame_err).
module image_stream_loader
  import image_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int NUM_WORDS   = 16384,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_serial,
  output logic [ADDR_W-1:0] address,
  output logic [ROW_W-1:0]  input_din1,
  output logic [ROW_W-1:0]  input_din2,
  output logic [ROW_W-1:0]  input_din3,
  output logic              wr_strobe,
  output logic              transfer_done,
  output logic              frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [ADDR_W:0] NUM_WORDS_C = (ADDR_W + 1)'(NUM_WORDS);
  localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_WORD - 1);

  logic [7:0]        rx_byte;
  logic              byte_valid, stop_err;
  logic [3:0]        byte_idx, idx_base;
  logic [WORD_W-1:0] shadow;
  logic              commit_pend;
  logic [ADDR_W:0]   word_cnt;
  logic              full, last_commit, accept, timeout_hit;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .stop_err  (stop_err)
  );

  // Once the image is complete (or about to be), further bytes are ignored.
  assign full        = (word_cnt == NUM_WORDS_C);
  assign last_commit = commit_pend && ((word_cnt + 1'b1) == NUM_WORDS_C);
  assign accept      = byte_valid && !full && !last_commit;
  // A byte landing in the commit cycle starts the next word at index 0.
  assign idx_base    = commit_pend ? 4'd0 : byte_idx;

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt;

  assign timeout_hit = (byte_idx != 4'd0) && !commit_pend &&
                       (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Idle counter runs only while a partial word is waiting for its next byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (byte_valid || commit_pend || byte_idx == 4'd0 || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Packer, word commit, completion and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx      <= 4'd0;
      shadow        <= '0;
      commit_pend   <= 1'b0;
      word_cnt      <= '0;
      address       <= '0;
      input_din1    <= '0;
      input_din2    <= '0;
      input_din3    <= '0;
      wr_strobe     <= 1'b0;
      transfer_done <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      wr_strobe     <= 1'b0;
      transfer_done <= transfer_done | full;
      if (stop_err) begin
        frame_err <= 1'b1;
      end
      if (commit_pend) begin
        input_din1  <= shadow[3*ROW_W-1:2*ROW_W];
        input_din2  <= shadow[2*ROW_W-1:ROW_W];
        input_din3  <= shadow[ROW_W-1:0];
        address     <= word_cnt[ADDR_W-1:0];
        wr_strobe   <= 1'b1;
        word_cnt    <= word_cnt + 1'b1;
        byte_idx    <= 4'd0;
        commit_pend <= 1'b0;
      end
      if (accept) begin
        // First byte shifts up to [71:64], so p0 ends up in din1[23:16].
        shadow <= {shadow[WORD_W-9:0], rx_byte};
        if (idx_base == LAST_IDX) begin
          byte_idx    <= LAST_IDX + 4'd1;
          commit_pend <= 1'b1;
        end else begin
          byte_idx <= idx_base + 4'd1;
        end
      end else if (timeout_hit) begin
        byte_idx  <= 4'd0;
        shadow    <= '0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_image_stream_loader.sv
// Self-checking bench for image_stream_loader: 16 clk/bit, NUM_WORDS=4.
// A byte-level reference model predicts each committed word; a monitor
// checks every wr_strobe against it. Define RX_TIMEOUT_EN to add the
// timeout scenario (TIMEOUT_CYC=500).
module tb_image_stream_loader;

  localparam int CPB       = 16;
  localparam int NUM_WORDS = 4;

  typedef struct packed {
    logic [15:0] addr;
    logic [71:0] word;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] address;
  logic [23:0] input_din1, input_din2, input_din3;
  logic        wr_strobe, transfer_done, frame_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          strobes;
  logic        done_due;

  exp_t        exp_q[$];
  logic [7:0]  m_bytes[$];
  int          m_count;
  logic [15:0] m_last_addr;
  logic [71:0] m_last_word;

  image_stream_loader #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (100_000),
    .NUM_WORDS  (NUM_WORDS),
    .TIMEOUT_CYC(500)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (rx),
    .address      (address),
    .input_din1   (input_din1),
    .input_din2   (input_din2),
    .input_din3   (input_din3),
    .wr_strobe    (wr_strobe),
    .transfer_done(transfer_done),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe must match the next predicted word; done follows the last one.
  always @(negedge clk) begin
    if (rst) begin
      strobes  <= 0;
      done_due <= 1'b0;
    end else if (wr_strobe) begin
      strobes <= strobes + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 72'(1), 72'(0));
      end else begin
        chk("address", 72'(address), 72'(exp_q[0].addr));
        chk("window", {input_din1, input_din2, input_din3}, exp_q[0].word);
        chk("done_low_at_strobe", 72'(transfer_done), 72'(0));
        done_due <= exp_q[0].last;
        exp_q.delete(0);
      end
    end else if (done_due) begin
      chk("done_rise", 72'(transfer_done), 72'(1));
      done_due <= 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    m_bytes.delete();
    exp_q.delete();
    m_count     = 0;
    m_last_addr = 16'd0;
    m_last_word = 72'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Model: collect accepted bytes; every 9 form one word at the running count.
  task automatic send_good(input logic [7:0] b, input int gap);
    logic [71:0] w;
    if (m_count < NUM_WORDS) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 9) begin
        w = 72'd0;
        for (int k = 0; k < 9; k++) w = {w[63:0], m_bytes[k]};
        exp_q.push_back('{addr: 16'(m_count), word: w, last: (m_count + 1 == NUM_WORDS)});
        m_last_addr = 16'(m_count);
        m_last_word = w;
        m_count++;
        m_bytes.delete();
      end
    end
    send_frame(b, 1'b1);
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_drained(input string tag);
    repeat (20) @(negedge clk);
    chk(tag, 72'(exp_q.size()), 72'(0));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset state and a single word 01..09
    do_reset();
    chk("rst_address", 72'(address), 72'(0));
    chk("rst_din", {input_din1, input_din2, input_din3}, 72'(0));
    chk("rst_strobe", 72'(wr_strobe), 72'(0));
    chk("rst_done", 72'(transfer_done), 72'(0));
    chk("rst_ferr", 72'(frame_err), 72'(0));
    for (int i = 1; i <= 9; i++) send_good(8'(i), $urandom_range(0, 10));
    check_drained("t1_drained");
    chk("t1_strobes", 72'(strobes), 72'(1));
    chk("t1_din1", 72'(input_din1), 72'(24'h010203));
    chk("t1_din2", 72'(input_din2), 72'(24'h040506));
    chk("t1_din3", 72'(input_din3), 72'(24'h070809));
    chk("t1_done", 72'(transfer_done), 72'(0));

    // Test 2: full image of 36 bytes, then an extra byte that must be ignored
    do_reset();
    for (int i = 0; i < 36; i++) send_good(8'(i), $urandom_range(0, 20));
    check_drained("t2_drained");
    chk("t2_strobes", 72'(strobes), 72'(4));
    chk("t2_last_word", {input_din1, input_din2, input_din3}, 72'h1B1C1D_1E1F20_212223);
    chk("t2_last_addr", 72'(address), 72'(3));
    send_good(8'h24, 10);
    check_drained("t2_extra_drained");
    chk("t2_freeze_addr", 72'(address), 72'(m_last_addr));
    chk("t2_freeze_din", {input_din1, input_din2, input_din3}, m_last_word);
    chk("t2_done_sticky", 72'(transfer_done), 72'(1));
    chk("t2_no_err", 72'(frame_err), 72'(0));
    chk("t2_strobes_after", 72'(strobes), 72'(4));

    // Test 3: glitch, then a bad stop bit in the middle of a word
    do_reset();
    for (int i = 0; i < 4; i++) send_good(8'($urandom), 5);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_glitch_ferr", 72'(frame_err), 72'(0));
    send_frame(8'h5A, 1'b0);
    repeat (40) @(negedge clk);
    chk("t3_bad_stop_ferr", 72'(frame_err), 72'(1));
    for (int i = 0; i < 5; i++) send_good(8'($urandom), 5);
    check_drained("t3_drained");
    chk("t3_strobes", 72'(strobes), 72'(1));

    // Test 4: reset in the middle of byte 5 of word 2
    do_reset();
    for (int i = 0; i < 22; i++) send_good(8'($urandom), 3);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    m_bytes.delete();
    exp_q.delete();
    m_count = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_rst_addr", 72'(address), 72'(0));
    chk("t4_rst_din", {input_din1, input_din2, input_din3}, 72'(0));
    chk("t4_rst_flags", {69'd0, wr_strobe, transfer_done, frame_err}, 72'(0));
    repeat (40) @(negedge clk);
    for (int i = 0; i < 9; i++) send_good(8'(8'hAA + i), 2);
    check_drained("t4_drained");
    chk("t4_addr", 72'(address), 72'(0));
    chk("t4_window", {input_din1, input_din2, input_din3}, 72'hAAABAC_ADAEAF_B0B1B2);

    // Test 5: back-to-back bytes across commit boundaries
    do_reset();
    for (int i = 0; i < 27; i++) send_good(8'($urandom), 0);
    check_drained("t5_drained");
    chk("t5_strobes", 72'(strobes), 72'(3));
    chk("t5_ferr", 72'(frame_err), 72'(0));

`ifdef RX_TIMEOUT_EN
    // Test 6: partial word abandoned by timeout, then a clean word at address 0
    do_reset();
    for (int i = 0; i < 4; i++) send_good(8'($urandom), 0);
    repeat (600) @(negedge clk);
    m_bytes.delete();
    chk("t6_timeout_ferr", 72'(frame_err), 72'(1));
    chk("t6_no_strobe", 72'(strobes), 72'(0));
    for (int i = 0; i < 9; i++) send_good(8'(8'h40 + i), 2);
    check_drained("t6_drained");
    chk("t6_addr", 72'(address), 72'(0));
    chk("t6_window", {input_din1, input_din2, input_din3}, 72'h404142_434445_464748);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
